// File: rtl/wb_serial_master.sv
// Byte-stream driven Wishbone initiator: parses 'W'/'R' commands from a UART receiver,
// runs one classic Wishbone cycle, and returns ACK/NAK or read data bytes to a UART transmitter.
module wb_serial_master #(
  parameter int          TIMEOUT  = 1024,
  parameter logic [7:0]  ACK_BYTE = 8'h06,
  parameter logic [7:0]  NAK_BYTE = 8'h15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        busy_o
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    BUS  = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          we_q, we_d;
  logic          nak_q, nak_d;
  logic          last_resp;
  logic [7:0]    resp_byte;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      nak_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      nak_q   <= nak_d;
    end
  end

  // A NAK or a write answer is a single byte; a read answer is four bytes, LSB first.
  assign last_resp = nak_q || we_q || (cnt_q == 2'd3);

  always_comb begin
    if (nak_q)     resp_byte = NAK_BYTE;
    else if (we_q) resp_byte = ACK_BYTE;
    else           resp_byte = dat_q[{cnt_q, 3'b000} +: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    nak_d   = nak_q;
    case (state_q)
      IDLE: begin
        if (rx_valid_i) begin
          cnt_d = 2'd0;
          if (rx_data_i == 8'h57 || rx_data_i == 8'h52) begin
            we_d    = (rx_data_i == 8'h57);
            nak_d   = 1'b0;
            state_d = ADDR;
          end else begin
            nak_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ADDR: begin
        if (rx_valid_i) begin
          adr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            tmo_d   = '0;
            state_d = we_q ? DATA : BUS;
          end
        end
      end
      DATA: begin
        if (rx_valid_i) begin
          dat_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            tmo_d   = '0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        // An ack arriving on the final timeout cycle still counts as a normal completion.
        if (wb_ack_i) begin
          if (!we_q) dat_d = wb_dat_i;
          cnt_d   = 2'd0;
          state_d = RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          nak_d   = 1'b1;
          cnt_d   = 2'd0;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        if (tx_ready_i) begin
          if (last_resp) state_d = IDLE;
          else           cnt_d   = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_stb_o   = (state_q == BUS);
  assign wb_cyc_o   = wb_stb_o;
  assign wb_sel_o   = wb_stb_o ? 4'hF : 4'h0;
  assign wb_we_o    = wb_stb_o & we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign tx_valid_o = (state_q == RESP);
  assign tx_data_o  = tx_valid_o ? resp_byte : 8'h00;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_wb_serial_master.sv
// Bench for wb_serial_master: directed spec scenarios plus random commands, with a
// command-level model predicting bus transfers and response bytes.
module tb_wb_serial_master;

  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, busy;
  logic [3:0]  wb_sel;

  wb_serial_master #(.TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we), .wb_sel_o(wb_sel), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc),
    .wb_ack_i(wb_ack), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] bus_adr_q[$];
  logic [31:0] bus_dat_q[$];
  logic        bus_we_q[$];
  logic [3:0]  bus_sel_q[$];

  // Responder model: acks after ack_delay extra cycles of strobe, logs each acked transfer.
  int          stb_cycles   = 0;
  int          cyc_mismatch = 0;
  int          wait_cnt     = 0;
  int          ack_delay    = 0;
  bit          ack_en       = 1'b1;
  logic [31:0] slave_rdata  = 32'h0;

  always @(negedge clk) begin
    if (wb_stb === 1'b1) begin
      stb_cycles++;
      if (wb_cyc !== 1'b1) cyc_mismatch++;
      if (ack_en && wait_cnt == ack_delay) begin
        wb_ack   = 1'b1;
        wb_dat_i = slave_rdata;
        bus_adr_q.push_back(wb_adr);
        bus_dat_q.push_back(wb_dat_o);
        bus_we_q.push_back(wb_we);
        bus_sel_q.push_back(wb_sel);
      end else begin
        wb_ack   = 1'b0;
        wb_dat_i = $urandom;
      end
      wait_cnt++;
    end else begin
      if (wb_cyc !== 1'b0) cyc_mismatch++;
      wb_ack   = 1'b0;
      wb_dat_i = $urandom;
      wait_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  logic [7:0] cmd[9];
  int         cmd_len;

  task automatic set_write(input logic [31:0] a, input logic [31:0] d);
    cmd[0] = 8'h57;
    for (int i = 0; i < 4; i++) begin
      cmd[1+i] = a[8*i +: 8];
      cmd[5+i] = d[8*i +: 8];
    end
    cmd_len = 9;
  endtask

  task automatic set_read(input logic [31:0] a);
    cmd[0] = 8'h52;
    for (int i = 0; i < 4; i++) cmd[1+i] = a[8*i +: 8];
    cmd_len = 5;
  endtask

  task automatic set_junk(input logic [7:0] b);
    cmd[0]  = b;
    cmd_len = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = $urandom;
    repeat (gap) @(negedge clk);
  endtask

  // ready_mode: 0 always ready, 1 ready every other cycle, 2 random ready plus rx noise
  task automatic run_txn(input string tag, input int ready_mode, input int gap_max, input bit lat);
    bit          is_cmd, acked, hold;
    logic [31:0] e_adr, e_dat;
    logic        e_we;
    int          e_stb, got, cyc;
    logic [7:0]  held;

    exp_q.delete(); got_q.delete();
    bus_adr_q.delete(); bus_dat_q.delete(); bus_we_q.delete(); bus_sel_q.delete();
    is_cmd = (cmd[0] == 8'h57) || (cmd[0] == 8'h52);
    e_we   = (cmd[0] == 8'h57);
    e_adr  = {cmd[4], cmd[3], cmd[2], cmd[1]};
    e_dat  = {cmd[8], cmd[7], cmd[6], cmd[5]};
    acked  = is_cmd && ack_en && (ack_delay < TIMEOUT);
    e_stb  = !is_cmd ? 0 : (acked ? ack_delay + 1 : TIMEOUT);
    if (!acked)    exp_q.push_back(8'h15);
    else if (e_we) exp_q.push_back(8'h06);
    else for (int i = 0; i < 4; i++) exp_q.push_back(slave_rdata[8*i +: 8]);

    tx_ready   = 1'b0;
    stb_cycles = 0;
    for (int i = 0; i < cmd_len; i++)
      send_byte(cmd[i], (i == cmd_len - 1) ? 0 : $urandom_range(0, gap_max));
    if (lat) begin
      chk({tag, "_lat_stb"}, {31'd0, wb_stb}, 32'd1);
      @(negedge clk);
      chk({tag, "_lat_txv"}, {31'd0, tx_valid}, 32'd1);
    end

    got  = 0;
    hold = 1'b0;
    held = 8'h00;
    for (cyc = 0; cyc < TIMEOUT + 200; cyc++) begin
      @(negedge clk);
      if (hold) chk({tag, "_tx_hold"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held});
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = cyc[0];
        default: begin
          tx_ready = $urandom_range(0, 1);
          rx_valid = $urandom_range(0, 1);
          rx_data  = $urandom;
        end
      endcase
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        hold = 1'b0;
        got++;
        if (got == exp_q.size()) break;
      end else if (tx_valid) begin
        hold = 1'b1;
        held = tx_data;
      end
    end
    chk({tag, "_resp_count"}, got, exp_q.size());
    @(negedge clk);
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    chk({tag, "_idle_txv"}, {31'd0, tx_valid}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_tx_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    chk({tag, "_stb_cycles"}, stb_cycles, e_stb);
    chk({tag, "_bus_xfers"}, bus_adr_q.size(), acked ? 1 : 0);
    if (acked && bus_adr_q.size() == 1) begin
      chk({tag, "_adr"}, bus_adr_q[0], e_adr);
      chk({tag, "_we"}, {31'd0, bus_we_q[0]}, {31'd0, e_we});
      chk({tag, "_sel"}, {28'd0, bus_sel_q[0]}, 32'hF);
      if (e_we) chk({tag, "_dat"}, bus_dat_q[0], e_dat);
    end
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_stb"}, {31'd0, wb_stb}, 32'd0);
    chk({tag, "_cyc"}, {31'd0, wb_cyc}, 32'd0);
    chk({tag, "_txv"}, {31'd0, tx_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_adr"}, wb_adr, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] jb;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_stb", {31'd0, wb_stb}, 32'd0);
    chk("rst_txv", {31'd0, tx_valid}, 32'd0);
    chk("rst_txd", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_adr", wb_adr, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_we_sel", {27'd0, wb_we, wb_sel}, 32'd0);
    rst = 1'b0;

    ack_delay = 2; set_write(32'h8000_0010, 32'hDEAD_BEEF);
    run_txn("wr_spec", 0, 1, 1'b0);
    ack_delay = 0; set_write(32'h0000_0100, 32'hCAFE_F00D);
    run_txn("wr_minlat", 0, 0, 1'b1);
    ack_delay = 1; slave_rdata = 32'h1234_5678; set_read(32'h2000_0004);
    run_txn("rd_spec", 0, 0, 1'b0);
    ack_delay = 0; slave_rdata = 32'hA1B2_C3D4; set_read(32'h0000_0040);
    run_txn("rd_toggle", 1, 2, 1'b0);
    set_junk(8'h41);
    run_txn("bad_op", 0, 0, 1'b0);
    ack_delay = 3; slave_rdata = 32'h0BAD_F00D; set_read(32'h0000_0008);
    run_txn("after_bad", 0, 0, 1'b0);
    ack_en = 1'b0; set_write(32'h4000_0000, 32'h1111_2222);
    run_txn("wr_timeout", 0, 0, 1'b0);
    ack_en = 1'b1; ack_delay = TIMEOUT - 1; set_write(32'h4000_0004, 32'h3333_4444);
    run_txn("ack_on_tmo", 0, 0, 1'b0);

    send_byte(8'h57, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    reset_check("rst_addr");
    ack_en = 1'b0; set_read(32'h5555_0000);
    for (int i = 0; i < cmd_len; i++) send_byte(cmd[i], 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_bus_stb", {31'd0, wb_stb}, 32'd1);
    reset_check("rst_bus");
    ack_en = 1'b1; ack_delay = 1; set_write(32'h6000_000C, 32'h7777_8888);
    run_txn("post_rst", 0, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      int kind;
      kind        = $urandom_range(0, 9);
      ack_en      = ($urandom_range(0, 15) != 0);
      ack_delay   = $urandom_range(0, 5);
      slave_rdata = $urandom;
      if (kind == 0) begin
        do jb = 8'($urandom); while (jb == 8'h57 || jb == 8'h52);
        set_junk(jb);
      end else if (kind <= 5) begin
        set_write($urandom, $urandom);
      end else begin
        set_read($urandom);
      end
      run_txn("rand", $urandom_range(0, 2), 2, 1'b0);
    end
    ack_en = 1'b1;

    chk("cyc_eq_stb", cyc_mismatch, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
